// File: rtl/vend_pkg.sv
// vend_pkg: types and code points shared between vending_machine and
// vend_dispenser.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOTOR,
    ST_CHG_CHK,
    ST_REQ,
    ST_REL,
    ST_DONE,
    ST_FAULT
  } disp_state_t;

  // Change codes; the numeric value is the number of Rs.5 coins owed.
  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_15   = 2'b11;

  localparam logic [2:0] PRD_NONE = 3'b000;

  // Change code to number of Rs.5 coins to eject.
  function automatic logic [1:0] chng_to_coins(input logic [1:0] code);
    logic [1:0] n;
    case (code)
      CHG_5:   n = 2'd1;
      CHG_10:  n = 2'd2;
      CHG_15:  n = 2'd3;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vend_dispenser_if.sv
// vend_dispenser_if: transaction input from vending_machine, physical
// motor/hopper signals and status outputs of the dispenser.
interface vend_dispenser_if;
  logic       vld;
  logic [2:0] prd;
  logic [1:0] chng;
  logic       rdy;
  logic       motor_en;
  logic [2:0] motor_sel;
  logic       coin_req;
  logic       coin_ack;
  logic [5:0] coins_left;
  logic       done;
  logic       err;

  // Environment side: upstream FSM plus the coin hopper.
  modport master (
    output vld, prd, chng, coin_ack,
    input  rdy, motor_en, motor_sel, coin_req, coins_left, done, err
  );

  // Dispenser side.
  modport slave (
    input  vld, prd, chng, coin_ack,
    output rdy, motor_en, motor_sel, coin_req, coins_left, done, err
  );
endinterface

// File: rtl/vend_hs_timer.sv
// vend_hs_timer: reloadable handshake timeout counter. load clears the count
// (takes priority), run advances it; expire is high on the TIMEOUT-th cycle
// spent waiting and the count holds there.
module vend_hs_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = (cnt_q == CNT_LAST);

  // Next count: reload on state entry, otherwise advance until expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (run && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vend_dispenser.sv
// vend_dispenser: pulses the product motor for the selected slot, then ejects
// change one Rs.5 coin at a time over a 4-phase req/ack hopper handshake,
// tracking coin stock and latching faults (empty stock, ack timeout).
// Optional build macro VEND_DISP_REFILL_EN adds a refill input that reloads
// the coin stock while idle.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int PRD_PULSE_CYC = 4,
  parameter int ACK_TIMEOUT   = 16,
  parameter int COIN_INIT     = 32
) (
  input  logic              clk,
  input  logic              rst,
`ifdef VEND_DISP_REFILL_EN
  input  logic              refill,
`endif
  vend_dispenser_if.slave   bus
);

  localparam int MOT_W = $clog2(PRD_PULSE_CYC + 1);
  localparam logic [MOT_W-1:0] MOT_LAST  = MOT_W'(PRD_PULSE_CYC - 1);
  localparam logic [5:0]       STOCK_RST = 6'(COIN_INIT);

  disp_state_t      state_q, state_d;
  logic [MOT_W-1:0] mot_cnt_q, mot_cnt_d;
  logic [2:0]       motor_sel_q, motor_sel_d;
  logic [1:0]       coins_due_q, coins_due_d;
  logic [5:0]       coins_left_q, coins_left_d;

  logic tmr_load;
  logic tmr_run;
  logic tmr_expire;

  // Waiting on the hopper in either handshake phase runs the timeout.
  assign tmr_run = (state_q == ST_REQ) || (state_q == ST_REL);

  vend_hs_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_hs_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .run    (tmr_run),
    .expire (tmr_expire)
  );

  // Next-state and datapath updates; the timer is reloaded on the edge that
  // enters REQ or REL so it reads zero in the first cycle of each phase.
  always_comb begin
    state_d      = state_q;
    mot_cnt_d    = mot_cnt_q;
    motor_sel_d  = motor_sel_q;
    coins_due_d  = coins_due_q;
    coins_left_d = coins_left_q;
    tmr_load     = 1'b0;

    case (state_q)
      ST_IDLE: begin
`ifdef VEND_DISP_REFILL_EN
        if (refill) coins_left_d = STOCK_RST;
`endif
        // rdy is high in IDLE, so vld alone means an accepted transaction.
        if (bus.vld) begin
          motor_sel_d = bus.prd;
          coins_due_d = chng_to_coins(bus.chng);
          mot_cnt_d   = '0;
          state_d     = (bus.prd != PRD_NONE) ? ST_MOTOR : ST_CHG_CHK;
        end
      end

      ST_MOTOR: begin
        if (mot_cnt_q == MOT_LAST) begin
          mot_cnt_d = '0;
          state_d   = ST_CHG_CHK;
        end else begin
          mot_cnt_d = mot_cnt_q + MOT_W'(1);
        end
      end

      ST_CHG_CHK: begin
        if (coins_due_q == 2'd0) begin
          state_d = ST_DONE;
        end else if (coins_left_q == 6'd0) begin
          state_d = ST_FAULT;
        end else begin
          state_d  = ST_REQ;
          tmr_load = 1'b1;
        end
      end

      ST_REQ: begin
        // An ack arriving on the expiry cycle still counts as delivered.
        if (bus.coin_ack) begin
          coins_due_d  = coins_due_q - 2'd1;
          coins_left_d = coins_left_q - 6'd1;
          state_d      = ST_REL;
          tmr_load     = 1'b1;
        end else if (tmr_expire) begin
          state_d = ST_FAULT;
        end
      end

      ST_REL: begin
        if (!bus.coin_ack) begin
          state_d = ST_CHG_CHK;
        end else if (tmr_expire) begin
          state_d = ST_FAULT;
        end
      end

      ST_DONE:  state_d = ST_IDLE;

      ST_FAULT: state_d = ST_FAULT;

      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mot_cnt_q    <= '0;
      motor_sel_q  <= '0;
      coins_due_q  <= '0;
      coins_left_q <= STOCK_RST;
    end else begin
      state_q      <= state_d;
      mot_cnt_q    <= mot_cnt_d;
      motor_sel_q  <= motor_sel_d;
      coins_due_q  <= coins_due_d;
      coins_left_q <= coins_left_d;
    end
  end

  // Outputs decode directly from the registered state, so they are glitch-free
  // and coin_req drops on the same edge that leaves REQ.
  assign bus.rdy        = (state_q == ST_IDLE);
  assign bus.motor_en   = (state_q == ST_MOTOR);
  assign bus.motor_sel  = motor_sel_q;
  assign bus.coin_req   = (state_q == ST_REQ);
  assign bus.coins_left = coins_left_q;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.err        = (state_q == ST_FAULT);

endmodule

// File: tb/tb_vend_dispenser.sv
// tb_vend_dispenser: two dispensers (default stock, and stock of 2), a 4-phase
// hopper model per instance, a stimulus process that queues hand-computed
// expectations, and a negedge monitor that scores completed transactions and
// requested output snapshots.
module tb_vend_dispenser;
  import vend_pkg::*;

  typedef struct packed {
    logic [63:0] name;
    logic        fault;
    logic [2:0]  sel;
    int          mot;
    int          hs;
    logic [5:0]  cl;
    int          lat;
    int          run;
  } txn_t;

  typedef struct packed {
    logic [63:0] name;
    logic        inst;
    logic        rdy;
    logic        men;
    logic        req;
    logic        done;
    logic        err;
    logic [2:0]  sel;
    logic [5:0]  cl;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a  [2];
  logic       vld_a  [2];
  logic [2:0] prd_a  [2];
  logic [1:0] chng_a [2];
  logic       ack_a  [2];
  logic       hop_en [2];
`ifdef VEND_DISP_REFILL_EN
  logic       refill_a [2];
`endif

  logic       rdy_o  [2];
  logic       men_o  [2];
  logic [2:0] sel_o  [2];
  logic       req_o  [2];
  logic [5:0] cl_o   [2];
  logic       done_o [2];
  logic       err_o  [2];

  vend_dispenser_if if0 ();
  vend_dispenser_if if1 ();

  assign if0.vld = vld_a[0];  assign if0.prd = prd_a[0];
  assign if0.chng = chng_a[0]; assign if0.coin_ack = ack_a[0];
  assign if1.vld = vld_a[1];  assign if1.prd = prd_a[1];
  assign if1.chng = chng_a[1]; assign if1.coin_ack = ack_a[1];

  assign rdy_o[0] = if0.rdy;  assign men_o[0] = if0.motor_en; assign sel_o[0] = if0.motor_sel;
  assign req_o[0] = if0.coin_req; assign cl_o[0] = if0.coins_left;
  assign done_o[0] = if0.done; assign err_o[0] = if0.err;
  assign rdy_o[1] = if1.rdy;  assign men_o[1] = if1.motor_en; assign sel_o[1] = if1.motor_sel;
  assign req_o[1] = if1.coin_req; assign cl_o[1] = if1.coins_left;
  assign done_o[1] = if1.done; assign err_o[1] = if1.err;

  vend_dispenser #(.PRD_PULSE_CYC(4), .ACK_TIMEOUT(16), .COIN_INIT(32)) dut0 (
    .clk    (clk),
    .rst    (rst_a[0]),
`ifdef VEND_DISP_REFILL_EN
    .refill (refill_a[0]),
`endif
    .bus    (if0)
  );

  vend_dispenser #(.PRD_PULSE_CYC(4), .ACK_TIMEOUT(16), .COIN_INIT(2)) dut1 (
    .clk    (clk),
    .rst    (rst_a[1]),
`ifdef VEND_DISP_REFILL_EN
    .refill (refill_a[1]),
`endif
    .bus    (if1)
  );

  int    n_vec = 0;
  int    n_err = 0;
  txn_t  txq [2][$];
  snap_t snq [$];

  // Hopper: raise ack on the second cycle req is seen, drop it once req falls.
  int hcnt [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst_a[i] || !hop_en[i]) begin
        ack_a[i] = 1'b0;
        hcnt[i]  = 0;
      end else if (!ack_a[i]) begin
        if (req_o[i] === 1'b1) begin
          hcnt[i] = hcnt[i] + 1;
          if (hcnt[i] == 2) begin
            ack_a[i] = 1'b1;
            hcnt[i]  = 0;
          end
        end else begin
          hcnt[i] = 0;
        end
      end else if (req_o[i] !== 1'b1) begin
        ack_a[i] = 1'b0;
      end
    end
  end

  task automatic chk(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s (dut%0d): got %0d, expected %0d", nm, inst, act, exp);
    end
  endtask

  // Monitor state per instance.
  int         lat_c [2];
  int         mot_c [2];
  int         hs_c  [2];
  int         run_c [2];
  int         last_run [2];
  logic       busy [2];
  logic       err_prev [2];
  logic       req_prev [2];
  logic [2:0] sel_seen [2];

  always @(negedge clk) begin
    txn_t  t;
    snap_t s;
    string nm;
    for (int i = 0; i < 2; i++) begin
      if (rst_a[i] !== 1'b0) begin
        lat_c[i] = 0; mot_c[i] = 0; hs_c[i] = 0; run_c[i] = 0; last_run[i] = 0;
        busy[i] = 1'b0; err_prev[i] = 1'b0; req_prev[i] = 1'b0; sel_seen[i] = 3'd0;
      end else begin
        if (busy[i]) lat_c[i] = lat_c[i] + 1;
        if (vld_a[i] && rdy_o[i] === 1'b1) begin
          busy[i] = 1'b1; lat_c[i] = 0; mot_c[i] = 0; hs_c[i] = 0;
          run_c[i] = 0; last_run[i] = 0; sel_seen[i] = 3'd0;
        end
        if (men_o[i] === 1'b1) begin
          mot_c[i]    = mot_c[i] + 1;
          sel_seen[i] = sel_o[i];
        end
        if (req_o[i] === 1'b1) begin
          if (!req_prev[i]) begin
            hs_c[i]  = hs_c[i] + 1;
            run_c[i] = 1;
          end else begin
            run_c[i] = run_c[i] + 1;
          end
        end else if (req_prev[i]) begin
          last_run[i] = run_c[i];
        end
        if (done_o[i] === 1'b1 || (err_o[i] === 1'b1 && !err_prev[i])) begin
          if (txq[i].size() == 0) begin
            chk(i, "spurious_done", {31'd0, done_o[i]}, 32'd0);
            chk(i, "spurious_err", {31'd0, err_o[i] & ~err_prev[i]}, 32'd0);
          end else begin
            t  = txq[i].pop_front();
            nm = $sformatf("%s", t.name);
            chk(i, {nm, ".fault"}, {31'd0, err_o[i]}, {31'd0, t.fault});
            chk(i, {nm, ".done"}, {31'd0, done_o[i]}, {31'd0, ~t.fault});
            chk(i, {nm, ".sel"}, {29'd0, sel_seen[i]}, {29'd0, t.sel});
            chk(i, {nm, ".motor_cyc"}, mot_c[i], t.mot);
            chk(i, {nm, ".coin_hs"}, hs_c[i], t.hs);
            chk(i, {nm, ".coins_left"}, {26'd0, cl_o[i]}, {26'd0, t.cl});
            if (t.lat >= 0) chk(i, {nm, ".latency"}, lat_c[i], t.lat);
            if (t.run >= 0) chk(i, {nm, ".req_cycles"}, last_run[i], t.run);
          end
          busy[i] = 1'b0;
        end
        req_prev[i] = (req_o[i] === 1'b1);
        err_prev[i] = (err_o[i] === 1'b1);
      end
    end
    while (snq.size() != 0) begin
      s  = snq.pop_front();
      nm = $sformatf("%s", s.name);
      chk(s.inst, {nm, ".rdy"},        {31'd0, rdy_o[s.inst]},  {31'd0, s.rdy});
      chk(s.inst, {nm, ".motor_en"},   {31'd0, men_o[s.inst]},  {31'd0, s.men});
      chk(s.inst, {nm, ".coin_req"},   {31'd0, req_o[s.inst]},  {31'd0, s.req});
      chk(s.inst, {nm, ".done"},       {31'd0, done_o[s.inst]}, {31'd0, s.done});
      chk(s.inst, {nm, ".err"},        {31'd0, err_o[s.inst]},  {31'd0, s.err});
      chk(s.inst, {nm, ".motor_sel"},  {29'd0, sel_o[s.inst]},  {29'd0, s.sel});
      chk(s.inst, {nm, ".coins_left"}, {26'd0, cl_o[s.inst]},   {26'd0, s.cl});
    end
  end

  task automatic expect_txn(input int i, input logic [63:0] name, input logic fault,
                            input logic [2:0] sel, input int mot, input int hs,
                            input logic [5:0] cl, input int lat, input int run);
    txn_t t;
    t.name = name; t.fault = fault; t.sel = sel; t.mot = mot; t.hs = hs;
    t.cl = cl; t.lat = lat; t.run = run;
    txq[i].push_back(t);
  endtask

  // Queue an output snapshot; the monitor scores it on the coming negedge.
  task automatic snap(input int i, input logic [63:0] name, input logic rdy, input logic men,
                      input logic req, input logic done, input logic err,
                      input logic [2:0] sel, input logic [5:0] cl);
    snap_t s;
    s.name = name; s.inst = i[0]; s.rdy = rdy; s.men = men; s.req = req;
    s.done = done; s.err = err; s.sel = sel; s.cl = cl;
    snq.push_back(s);
    @(negedge clk);
  endtask

  task automatic send(input int i, input logic [2:0] p, input logic [1:0] c);
    @(posedge clk); #1;
    vld_a[i] = 1'b1; prd_a[i] = p; chng_a[i] = c;
    @(posedge clk); #1;
    vld_a[i] = 1'b0;
  endtask

  task automatic drain(input int i, input int budget);
    for (int k = 0; k < budget && txq[i].size() != 0; k++) begin
      @(posedge clk); #1;
    end
    if (txq[i].size() != 0) begin
      $display("FAIL drain_timeout (dut%0d): %0d transactions outstanding, expected 0", i, txq[i].size());
      $fatal(1, "transaction did not complete");
    end
  endtask

  task automatic pulse_rst(input int i);
    @(posedge clk); #1;
    rst_a[i] = 1'b1;
    @(posedge clk); #1;
    rst_a[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_a[i] = 1'b1; vld_a[i] = 1'b0; prd_a[i] = 3'd0; chng_a[i] = 2'd0;
      ack_a[i] = 1'b0; hop_en[i] = 1'b1;
`ifdef VEND_DISP_REFILL_EN
      refill_a[i] = 1'b0;
`endif
    end
    repeat (2) @(posedge clk);
    #1;
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;

    snap(0, "reset0", 1, 0, 0, 0, 0, 3'd0, 6'd32);
    snap(1, "reset1", 1, 0, 0, 0, 0, 3'd0, 6'd2);

    expect_txn(0, "prd_chg", 0, 3'd1, 4, 1, 6'd31, 10, -1);
    send(0, 3'd1, CHG_5);  drain(0, 60);

    expect_txn(0, "nop", 0, 3'd0, 0, 0, 6'd31, 2, -1);
    send(0, PRD_NONE, CHG_NONE);  drain(0, 60);

    expect_txn(0, "prd_only", 0, 3'd5, 4, 0, 6'd31, 6, -1);
    send(0, 3'd5, CHG_NONE);  drain(0, 60);

    expect_txn(0, "chg15", 0, 3'd0, 0, 3, 6'd28, 14, -1);
    send(0, PRD_NONE, CHG_15);  drain(0, 60);

    // Second vld while the motor runs must be dropped.
    expect_txn(0, "busy", 0, 3'd3, 4, 0, 6'd28, 6, -1);
    send(0, 3'd3, CHG_NONE);
    vld_a[0] = 1'b1; prd_a[0] = 3'd7; chng_a[0] = CHG_15;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vld_a[0] = 1'b0;
    drain(0, 60);
    repeat (3) begin @(posedge clk); #1; end
    snap(0, "bsy_idle", 1, 0, 0, 0, 0, 3'd3, 6'd28);

    // Stock of 2 runs out after two of three coins.
    expect_txn(1, "empty", 1, 3'd2, 4, 2, 6'd0, 14, -1);
    send(1, 3'd2, CHG_15);  drain(1, 60);
    @(posedge clk); #1;
    snap(1, "flt_hold", 0, 0, 0, 0, 1, 3'd2, 6'd0);
    pulse_rst(1);
    snap(1, "rst_clr", 1, 0, 0, 0, 0, 3'd0, 6'd2);

    // Hopper silent: fault after 16 cycles of coin_req, no decrement.
    hop_en[0] = 1'b0;
    expect_txn(0, "timeout", 1, 3'd0, 0, 1, 6'd28, 18, 16);
    send(0, PRD_NONE, CHG_5);  drain(0, 60);
    send(0, 3'd1, CHG_NONE);
    repeat (8) begin @(posedge clk); #1; end
    snap(0, "flt_ign", 0, 0, 0, 0, 1, 3'd0, 6'd28);

    pulse_rst(0);
    snap(0, "rst_idle", 1, 0, 0, 0, 0, 3'd0, 6'd32);

    // Reset while waiting in REQ.
    send(0, PRD_NONE, CHG_5);
    for (int k = 0; k < 10 && req_o[0] !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    if (req_o[0] !== 1'b1) begin
      $display("FAIL wait_req (dut0): coin_req=%0d, expected 1", req_o[0]);
      $fatal(1, "coin_req never asserted");
    end
    rst_a[0] = 1'b1;
    @(posedge clk); #1;
    rst_a[0] = 1'b0;
    snap(0, "rst_mid", 1, 0, 0, 0, 0, 3'd0, 6'd32);

    hop_en[0] = 1'b1;
    expect_txn(0, "post_rst", 0, 3'd4, 4, 2, 6'd30, 14, -1);
    send(0, 3'd4, CHG_10);  drain(0, 60);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Downstream stage of vending_machine. Consumes its product code (prd) and change code (chng) and drives the physical outputs.
- Pulses the product motor for the selected slot, then ejects change as Rs.5 coins through a coin-hopper req/ack handshake.
- Tracks the remaining coin stock and flags faults.

Parameters:
- PRD_PULSE_CYC, 4, cycles motor_en is held high per vend (>=1)
- ACK_TIMEOUT, 16, max cycles waiting on coin_ack rise or fall before fault
- COIN_INIT, 32, Rs.5 coin stock loaded at reset (<=63)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- vld  in  1  transaction strobe from vending_machine; prd/chng valid this cycle
- prd  in  3  product code; 3'b000 = no product, else slot id
- chng  in  2  change code: 00 none, 01 Rs.5, 10 Rs.10, 11 Rs.15
- rdy  out  1  high only in IDLE; vld is accepted only when vld && rdy
- motor_en  out  1  product motor drive
- motor_sel  out  3  latched slot id; valid while motor_en is high
- coin_req  out  1  request one Rs.5 coin from the hopper
- coin_ack  in  1  hopper acknowledge (4-phase)
- coins_left  out  6  current Rs.5 stock
- done  out  1  one-cycle pulse when a transaction completes
- err  out  1  sticky fault (empty stock or ack timeout)

Behaviour:
- Reset values: rdy=1, motor_en=0, motor_sel=0, coin_req=0, done=0, err=0, coins_left=COIN_INIT. Internal latches and counters clear to 0. FSM returns to IDLE from any state, including mid-handshake.
- FSM states: IDLE, MOTOR, CHG_CHK, REQ, REL, DONE, FAULT.
- IDLE:
  - On vld && rdy: latch prd into motor_sel and chng into coins_due (2 bits; value = number of Rs.5 coins).
  - Next state is MOTOR if prd != 0, else CHG_CHK.
  - vld while not rdy is ignored; no queueing.
- MOTOR: motor_en=1 for exactly PRD_PULSE_CYC cycles, then CHG_CHK.
- CHG_CHK (1 cycle), priority order:
  - coins_due == 0 -> DONE
  - coins_left == 0 -> FAULT
  - otherwise -> REQ
- REQ:
  - coin_req=1.
  - On coin_ack==1: coins_due--, coins_left-- (same cycle), drop coin_req, go to REL.
- REL: coin_req=0. Wait for coin_ack==0, then CHG_CHK.
- Timeout: a timer reloads on each entry to REQ or REL. If it reaches ACK_TIMEOUT in either state -> FAULT with coin_req=0. No decrement occurs on timeout.
- DONE: done=1 for one cycle, then IDLE.
- FAULT: err=1. All outputs idle, rdy=0. Exited only by rst.
- Latency examples:
  - prd!=0, chng=00: vld accepted at cycle 0 -> done at cycle PRD_PULSE_CYC+2.
  - prd=0, chng=00: done at cycle 2.
- Arithmetic: coins_left never wraps. Decrement happens only on an ack in REQ, and CHG_CHK guarantees stock > 0 before entering REQ.
- Partial change: stock running out mid-transaction still ends in FAULT. The coins already ejected remain deducted.
- coin_ack high while in IDLE/MOTOR/DONE is ignored.

Optional Feature:
- Macro: VEND_DISP_REFILL_EN
- Defined:
  - Adds input port refill (1 bit).
  - refill==1 while in IDLE loads coins_left=COIN_INIT on the next edge.
  - If vld && rdy occurs in the same cycle, the refill still loads and the transaction is accepted normally.
  - refill outside IDLE is ignored. Refill does not clear err.
- Undefined: no refill port; stock is restored only by rst.

Decomposition:
- Package vend_pkg holds:
  - enum disp_state_t
  - chng code localparams: CHG_NONE=2'b00, CHG_5=2'b01, CHG_10=2'b10, CHG_15=2'b11
  - PRD_NONE=3'b000
  - shared with vending_machine
- One natural sub-module: vend_hs_timer, the reloadable timeout counter with an expire flag, used for REQ/REL.

Test Plan:
- Reset check: rst=1 for 2 cycles -> rdy=1, coins_left=32, all other outputs 0.
- Product plus change: prd=3'b001, chng=01, vld pulse; hopper acks 2 cycles after each req -> motor_en high 4 cycles with motor_sel=001, one coin_req handshake, done pulse, coins_left=31.
- Change only: prd=000, chng=11 -> no motor_en, three complete req/ack handshakes, coins_left=29, single done.
- Empty stock: COIN_INIT=2, prd=010, chng=11 -> two coins ejected, then err=1, rdy=0, coins_left=0, no done. rst clears err and restores coins_left=2.
- Ack timeout: chng=01, hopper never acks -> coin_req drops and err=1 exactly 16 cycles after REQ entry. vld afterwards is ignored.
- Reset mid-handshake and vld while busy: vld during MOTOR is ignored (single done, one motor pulse). rst asserted in REQ -> coin_req=0 and IDLE on the next edge, coins_left=COIN_INIT.
